// File: rtl/sp_pkg.sv
// Shared servo/optimizer package: command codes, default timing and a
// parameter sanity helper used at elaboration time.
package sp_pkg;

    // Step command codes carried on cmd_dir.
    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_INC    = 2'b01,
        CMD_DEC    = 2'b10,
        CMD_CENTER = 2'b11
    } cmd_e;

    // Default timing for a 100 MHz clock: 20 ms frame, 0.5..2.5 ms pulse.
    localparam int unsigned DEF_PERIOD_CYC = 2_000_000;
    localparam int unsigned DEF_PW_MIN     = 50_000;
    localparam int unsigned DEF_PW_MAX     = 250_000;
    localparam int unsigned DEF_PW_CENTER  = 150_000;
    localparam int unsigned DEF_STEP       = 1_000;
    localparam int          DEF_POS_W      = 32;

    // True when the pulse window fits inside the frame and steps are non-zero.
    function automatic bit params_ok(input int unsigned period_cyc,
                                     input int unsigned pw_min,
                                     input int unsigned pw_center,
                                     input int unsigned pw_max,
                                     input int unsigned step);
        return (pw_min <= pw_center) && (pw_center <= pw_max) &&
               (pw_max < period_cyc) && (step >= 1);
    endfunction

endpackage

// File: rtl/servo_pwm_slew_if.sv
// Command and drive bundle between the optimizer (master) and one servo axis (slave).
//
// Handshake: a command transfers on a rising CLK edge where cmd_valid and
// cmd_ready are both high. The master holds cmd_valid/cmd_dir stable until
// that edge; cmd_ready stays low from the edge after a transfer until the
// command has been applied at the next frame wrap.
interface servo_pwm_slew_if #(
    parameter int POS_W = 32
);
    import sp_pkg::*;

    logic             en;
    logic             cmd_valid;
    cmd_e             cmd_dir;
    logic             cmd_ready;
    logic             pwm;
    logic [POS_W-1:0] position;
    logic             limit_hi;
    logic             limit_lo;
    logic             frame_start;

    modport master (
        output en, cmd_valid, cmd_dir,
        input  cmd_ready, pwm, position, limit_hi, limit_lo, frame_start
    );

    modport slave (
        input  en, cmd_valid, cmd_dir,
        output cmd_ready, pwm, position, limit_hi, limit_lo, frame_start
    );

endinterface

// File: rtl/servo_frame_timer.sv
// Free-running frame counter 0..PERIOD_CYC-1 with a wrap strobe and a
// registered frame_start marking the first cycle of every frame after the first.
module servo_frame_timer #(
    parameter int unsigned PERIOD_CYC = 2_000_000,
    parameter int          CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

    assign wrap = (cnt == LAST);

    // Count every cycle and wrap; frame_start is the wrap strobe delayed one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            cnt         <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_pwm_slew.sv
// One servo axis: latches a step command, applies it with saturation at the
// frame boundary, and drives a registered fixed-period PWM pulse.
module servo_pwm_slew
    import sp_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int unsigned PW_MIN     = DEF_PW_MIN,
    parameter int unsigned PW_MAX     = DEF_PW_MAX,
    parameter int unsigned PW_CENTER  = DEF_PW_CENTER,
    parameter int unsigned STEP       = DEF_STEP,
    parameter int          POS_W      = DEF_POS_W
) (
    input logic            CLK,
    input logic            RST,
    servo_pwm_slew_if.slave bus
);

    if (!params_ok(PERIOD_CYC, PW_MIN, PW_CENTER, PW_MAX, STEP)) begin : g_bad_params
        $error("servo_pwm_slew: need PW_MIN <= PW_CENTER <= PW_MAX < PERIOD_CYC and STEP >= 1");
    end

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [POS_W:0]   wide_t;

    // One spare bit so INC cannot wrap before it is clamped.
    localparam wide_t MIN_X  = wide_t'(PW_MIN);
    localparam wide_t MAX_X  = wide_t'(PW_MAX);
    localparam wide_t CTR_X  = wide_t'(PW_CENTER);
    localparam wide_t STEP_X = wide_t'(STEP);

    logic [POS_W-1:0] cnt;
    logic             wrap;
    logic             frame_start;

    logic  pending_valid;
    cmd_e  pending_cmd;
    pos_t  position;      // applied pulse width; also the active PWM compare value
    pos_t  next_pos;
    wide_t pos_x;
    wide_t next_x;
    logic  limit_hi;
    logic  limit_lo;
    logic  pwm;

    servo_frame_timer #(
        .PERIOD_CYC (PERIOD_CYC),
        .CNT_W      (POS_W)
    ) u_timer (
        .CLK         (CLK),
        .RST         (RST),
        .cnt         (cnt),
        .wrap        (wrap),
        .frame_start (frame_start)
    );

    // Saturated result of the pending command; DEC compares before subtracting.
    always_comb begin
        pos_x  = {1'b0, position};
        next_x = pos_x;
        case (pending_cmd)
            CMD_INC:    next_x = (pos_x + STEP_X > MAX_X) ? MAX_X : pos_x + STEP_X;
            CMD_DEC:    next_x = (pos_x < MIN_X + STEP_X) ? MIN_X : pos_x - STEP_X;
            CMD_CENTER: next_x = CTR_X;
            default:    next_x = pos_x;
        endcase
        next_pos = next_x[POS_W-1:0];
    end

    // Command latch and frame-boundary apply; accept is blocked while pending.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_valid <= 1'b0;
            pending_cmd   <= CMD_HOLD;
            position      <= pos_t'(PW_CENTER);
            limit_hi      <= (PW_CENTER == PW_MAX);
            limit_lo      <= (PW_CENTER == PW_MIN);
        end else if (pending_valid) begin
            if (wrap) begin
                pending_valid <= 1'b0;
                position      <= next_pos;
                limit_hi      <= (next_x == MAX_X);
                limit_lo      <= (next_x == MIN_X);
            end
        end else if (bus.cmd_valid) begin
            pending_valid <= 1'b1;
            pending_cmd   <= bus.cmd_dir;
        end
    end

    // Registered pulse: high for cnt < position, forced low while disabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm <= 1'b0;
        end else begin
            pwm <= bus.en && (cnt < position);
        end
    end

    assign bus.cmd_ready   = !pending_valid;
    assign bus.pwm         = pwm;
    assign bus.position    = position;
    assign bus.limit_hi    = limit_hi;
    assign bus.limit_lo    = limit_lo;
    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_servo_pwm_slew.sv
// Bench for servo_pwm_slew: directed scenarios plus random commands, with a
// queue of expected applied positions checked by an independent monitor.
module tb_servo_pwm_slew;
    import sp_pkg::*;

    localparam int P  = 100;
    localparam int MN = 10;
    localparam int MX = 30;
    localparam int CT = 20;
    localparam int ST = 5;

    logic CLK = 1'b0;
    logic RST;

    servo_pwm_slew_if #(.POS_W(32)) bus ();

    servo_pwm_slew #(
        .PERIOD_CYC (P),
        .PW_MIN     (MN),
        .PW_MAX     (MX),
        .PW_CENTER  (CT),
        .STEP       (ST),
        .POS_W      (32)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    // Cycle position within the frame, from the frame-length rule alone.
    int cnt_m;
    bit seen_wrap;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_m     <= 0;
            seen_wrap <= 1'b0;
        end else if (cnt_m == P - 1) begin
            cnt_m     <= 0;
            seen_wrap <= 1'b1;
        end else begin
            cnt_m <= cnt_m + 1;
        end
    end

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    int model_pos  = CT;   // position after every accepted command
    int applied_pw = CT;   // position the DUT should currently be using

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out or missing expectation (t=%0t)", name, $time);
    endtask

    function automatic int ref_step(input int p, input cmd_e c);
        case (c)
            CMD_INC:    return (p + ST > MX) ? MX : p + ST;
            CMD_DEC:    return (p - ST < MN) ? MN : p - ST;
            CMD_CENTER: return CT;
            default:    return p;
        endcase
    endfunction

    // ---------------- monitor ----------------
    logic prev_ready = 1'b1;
    bit   have_frame = 1'b0;
    bit   en_d       = 1'b0;
    bit   all1, all0;
    int   hi_cnt     = 0;
    int   frame_pw   = CT;

    always @(negedge CLK) begin
        logic [31:0] e;
        if (RST) begin
            prev_ready = 1'b1;
            have_frame = 1'b0;
            en_d       = 1'b0;
            applied_pw = CT;
        end else begin
            chk("frame_start", 32'(bus.frame_start), 32'(cnt_m == 0 && seen_wrap));
            if (!en_d) chk("pwm_gated", 32'(bus.pwm), 32'd0);
            if (bus.cmd_ready && !prev_ready) begin
                chk("apply_on_wrap", 32'(cnt_m == 0), 32'd1);
                if (exp_q.size() == 0) begin
                    flag_fail("apply_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    chk("position", bus.position, e);
                    chk("limit_hi", 32'(bus.limit_hi), 32'(e == MX));
                    chk("limit_lo", 32'(bus.limit_lo), 32'(e == MN));
                    applied_pw = int'(e);
                end
            end
            prev_ready = bus.cmd_ready;
            if (bus.frame_start) begin
                if (have_frame) begin
                    if (all1)      chk("pulse_width", 32'(hi_cnt), 32'(frame_pw));
                    else if (all0) chk("pulse_off", 32'(hi_cnt), 32'd0);
                end
                have_frame = 1'b1;
                frame_pw   = applied_pw;
                hi_cnt     = 0;
                all1       = 1'b1;
                all0       = 1'b1;
            end
            hi_cnt += int'(bus.pwm);
            all1   = all1 && en_d;
            all0   = all0 && !en_d;
            en_d   = bus.en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_cnt(input int v);
        bit ok = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            @(posedge CLK);
            #1;
            if (cnt_m == v) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag_fail("wait_cnt");
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 3 * P; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        if (!ok) flag_fail("wait_ready");
    endtask

    // Offer a command and hold it until an edge where cmd_ready was high.
    task automatic send(input cmd_e c);
        bit r;
        bit ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = c;
        for (int i = 0; i < 3 * P; i++) begin
            r = bus.cmd_ready;
            @(posedge CLK);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = CMD_HOLD;
        if (!ok) begin
            flag_fail("send_accept");
        end else begin
            model_pos = ref_step(model_pos, c);
            exp_q.push_back(32'(model_pos));
            chk("ready_low_after_accept", 32'(bus.cmd_ready), 32'd0);
        end
    endtask

    task automatic check_idle_state(input string tag);
        chk({tag, "_pwm"},      32'(bus.pwm), 32'd0);
        chk({tag, "_position"}, bus.position, 32'(CT));
        chk({tag, "_ready"},    32'(bus.cmd_ready), 32'd1);
        chk({tag, "_limit_hi"}, 32'(bus.limit_hi), 32'd0);
        chk({tag, "_limit_lo"}, 32'(bus.limit_lo), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST           = 1'b1;
        bus.en        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = CMD_HOLD;

        repeat (2) @(posedge CLK);
        #1;
        check_idle_state("reset");
        chk("reset_frame_start", 32'(bus.frame_start), 32'd0);
        #2 RST = 1'b0;
        bus.en = 1'b1;

        // Idle frames: 20-cycle pulse, centred position.
        tick(3 * P + 5);
        chk("idle_position", bus.position, 32'(CT));

        // INC at cnt 40, then two more back-to-back INCs into the upper limit.
        wait_cnt(40);
        send(CMD_INC);
        send(CMD_INC);
        send(CMD_INC);
        wait_ready();
        chk("sat_hi_flag", 32'(bus.limit_hi), 32'd1);

        // Centre, three DECs into the lower limit, centre again, then HOLD.
        send(CMD_CENTER);
        send(CMD_DEC);
        send(CMD_DEC);
        send(CMD_DEC);
        send(CMD_CENTER);
        send(CMD_HOLD);
        wait_ready();
        tick(P + 5);

        // A fully disabled frame with an INC applied at its wrap.
        wait_cnt(P - 1);
        bus.en = 1'b0;
        wait_cnt(50);
        send(CMD_INC);
        wait_cnt(P - 1);
        bus.en = 1'b1;
        tick(2 * P + 5);
        chk("en_frame_position", bus.position, 32'(model_pos));

        // Random commands with random idle gaps.
        for (int k = 0; k < 40; k++) begin
            tick($urandom_range(0, 150));
            send(cmd_e'($urandom_range(0, 3)));
        end
        wait_ready();
        tick(2 * P + 5);

        // Reset mid-pulse with an INC pending: the INC must be discarded.
        wait_cnt(3);
        send(CMD_INC);
        wait_cnt(10);
        chk("pwm_high_before_reset", 32'(bus.pwm), 32'd1);
        chk("pending_before_reset", 32'(bus.cmd_ready), 32'd0);
        #2 RST = 1'b1;
        #1;
        exp_q.delete();
        model_pos = CT;
        check_idle_state("midreset");
        tick(2);
        #2 RST = 1'b0;
        tick(2 * P + 10);
        chk("post_reset_position", bus.position, 32'(CT));
        chk("post_reset_ready", 32'(bus.cmd_ready), 32'd1);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/servo_pwm_slew.md
# servo_pwm_slew

Per-axis servo drive stage that sits directly downstream of the `sp_optimizer` control FSM, with one instance each for the H and V axes. It accepts step commands (increment, decrement, centre, hold) over a valid/ready handshake and keeps a saturated pulse-width position. It generates a fixed-period servo PWM frame and applies each command only at a frame boundary, so a pulse is never cut or stretched mid-frame. Its outputs drive `SERVO_H`/`SERVO_V`, `servo_position_H/V` and `PWM_limit_H/V`.

## Interface
- `PERIOD_CYC`, 2_000_000: frame length in CLK cycles (20 ms at 100 MHz).
- `PW_MIN`, 50_000: minimum pulse width in cycles (0.5 ms).
- `PW_MAX`, 250_000: maximum pulse width in cycles (2.5 ms).
- `PW_CENTER`, 150_000: reset and centre pulse width.
- `STEP`, 1_000: pulse-width change per INC/DEC command.
- `POS_W`, 32: position width.
- `CLK  in  1`: system clock; all logic is on the rising edge.
- `RST  in  1`: asynchronous, active-high reset.
- `en  in  1`: output enable; when low, `pwm` is forced to 0.
- `cmd_valid  in  1`: a command is offered.
- `cmd_dir  in  2`: command code. 00 HOLD, 01 INC, 10 DEC, 11 CENTER.
- `cmd_ready  out  1`: no command is pending; a command can be accepted.
- `pwm  out  1`: registered servo pulse.
- `position  out  POS_W`: applied pulse width in cycles.
- `limit_hi  out  1`: high when `position == PW_MAX`.
- `limit_lo  out  1`: high when `position == PW_MIN`.
- `frame_start  out  1`: one-cycle pulse in the first cycle of each frame.

## Operation
- Parameter legality: `PW_MIN <= PW_CENTER <= PW_MAX < PERIOD_CYC` and `STEP >= 1`. An illegal set is an elaboration error.
- Frame counter `cnt` runs 0..PERIOD_CYC-1 and wraps to 0. It runs regardless of `en`.
- Accept: on an edge where `cmd_valid && cmd_ready`, latch `cmd_dir` into `pending`. `cmd_ready` goes to 0.
- Apply: on the wrap edge (`cnt == PERIOD_CYC-1`), if a command is pending:
  - update `position`, `active_pw` and the limit flags together;
  - clear `pending`;
  - set `cmd_ready` to 1.
- Command effects:
  - HOLD: accepted, applied as a no-op, and consumes the frame.
  - INC: `min(position+STEP, PW_MAX)`.
  - DEC: `max(position-STEP, PW_MIN)`, computed without underflow.
  - CENTER: `PW_CENTER`.
- Arithmetic is done in POS_W+1 bits before saturation.
- Accept and apply can never happen on the same edge, because accept requires that nothing is pending. At most one command is applied per frame.
- `pwm` next value is `en && (cnt < active_pw)`. This gives exactly `active_pw` high cycles per frame, starting one cycle after `cnt == 0`.
- Deasserting `en` mid-pulse drops `pwm` on the next edge. Reasserting `en` resumes within the current frame's window with no restart.

## Timing
- Reset values:
  - `cnt` = 0, `position` = `active_pw` = PW_CENTER;
  - `pwm` = 0, `frame_start` = 0;
  - `cmd_ready` = 1, `limit_hi` = `limit_lo` = 0, unless PW_CENTER equals PW_MIN or PW_MAX, in which case the matching flag resets to 1;
  - pending cleared.
- Reset asserted mid-frame or mid-pulse: all of the above take effect immediately and any pending command is discarded.
- `cmd_ready` falls on the edge after acceptance.
- Command latency: the command takes effect at the next wrap. `position` changes on the wrap edge, and the new pulse width appears in the pulse of the following frame.
- `frame_start` is high during the cycle with `cnt == 0` (registered from the wrap edge). The first frame after reset does not assert it.

## Structure
- Shared package `sp_pkg` holds:
  - command codes `CMD_HOLD`, `CMD_INC`, `CMD_DEC`, `CMD_CENTER`;
  - default timing constants, shared with the optimizer.
- One natural sub-module, `servo_frame_timer`: the parameterised wrapping counter. It outputs `cnt`, a `wrap` strobe and `frame_start`.
- The command latch, saturation logic and PWM compare stay in `servo_pwm_slew`.

## Test plan
All scenarios use `PERIOD_CYC=100`, `PW_MIN=10`, `PW_MAX=30`, `PW_CENTER=20`, `STEP=5`.

- **Reset release, `en`=1, no commands:** `pwm` is high exactly 20 of every 100 cycles; `position` = 20; both limits are 0; `frame_start` is high once per 100 cycles.
- **Single INC at `cnt` = 40:** `cmd_ready` is 0 from the next cycle; the current frame's pulse stays 20; `position` = 25 at the wrap edge; `cmd_ready` returns to 1 at the same edge; the next frame's pulse is 25.
- **Three INC commands, each issued as soon as `cmd_ready` is high:** `position` goes 25, 30, 30; `limit_hi` rises with 30 and stays high; the pulse is 30. A second `cmd_valid` held while `cmd_ready`=0 is not accepted until the wrap.
- **Three DEC commands from 20, then CENTER:** `position` goes 15, 10, 10, with `limit_lo` set at 10. CENTER restores 20 and clears `limit_lo`.
- **`RST` pulsed at `cnt` = 10 while `pwm`=1 and an INC is pending:** `pwm` is 0 immediately; after release `position` = 20, `cmd_ready` = 1, and the INC is never applied.
- **`en`=0 for a full frame with an INC applied at its wrap:** `pwm` stays 0 throughout while `position` still becomes 25. After `en`=1, the next full frame has a 25-cycle pulse.
